// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding select, stall/bubble generation and MD busy tracking for the 5-stage MIPS pipe.
// Define HAZ_PERF_EN to add saturating stall_cnt / md_stall_cnt performance counters.
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_D,
  input  logic [REG_AW-1:0] rt_D,
  input  logic [1:0]        tuse_rs_D,
  input  logic [1:0]        tuse_rt_D,
  input  logic [REG_AW-1:0] rs_E,
  input  logic [REG_AW-1:0] rt_E,
  input  logic [REG_AW-1:0] wa_E,
  input  logic [REG_AW-1:0] wa_M,
  input  logic [REG_AW-1:0] wa_W,
  input  logic              wen_E,
  input  logic              wen_M,
  input  logic              wen_W,
  input  logic [1:0]        tnew_E,
  input  logic              tnew_M,
  input  logic              md_start_E,
  input  logic              md_div_E,
  input  logic              md_use_D,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              stall,
  output logic              nop,
  output logic              md_busy,
`ifdef HAZ_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       md_stall_cnt,
`endif
  output logic [CNT_W-1:0]  md_cnt
);

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  MUL_LOAD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0]  DIV_LOAD = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] md_cnt_r;
  logic [CNT_W-1:0] md_cnt_nxt_s;
  logic             md_busy_r;
  logic             data_stall_s;
  logic             md_stall_s;
  logic             stall_s;
  logic             fwd_ad_s;
  logic             fwd_bd_s;
  logic [1:0]       fwd_ae_s;
  logic [1:0]       fwd_be_s;

  // E-stage operand source: M result (only once it exists) beats W; $0 never forwarded.
  function automatic logic [1:0] fwd_e_sel(input logic [REG_AW-1:0] src,
                                           input logic wen_m, input logic [REG_AW-1:0] wa_m,
                                           input logic tnew_m,
                                           input logic wen_w, input logic [REG_AW-1:0] wa_w);
    logic [1:0] sel;
    if (src != REG_ZERO && wen_m && wa_m == src && tnew_m == 1'b0) begin
      sel = 2'b10;
    end else if (src != REG_ZERO && wen_w && wa_w == src) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // A D-stage read stalls when a producer in E or M will not have its result before Tuse.
  function automatic logic data_hz(input logic [REG_AW-1:0] src, input logic [1:0] tuse,
                                   input logic wen_e, input logic [REG_AW-1:0] wa_e,
                                   input logic [1:0] tnew_e,
                                   input logic wen_m, input logic [REG_AW-1:0] wa_m,
                                   input logic tnew_m);
    return (src != REG_ZERO) && (tuse != 2'd3) &&
           ((wen_e && wa_e == src && tnew_e > tuse) ||
            (wen_m && wa_m == src && {1'b0, tnew_m} > tuse));
  endfunction

  // Forwarding selects and stall terms, all gated off while reset is held.
  always_comb begin
    data_stall_s = data_hz(rs_D, tuse_rs_D, wen_E, wa_E, tnew_E, wen_M, wa_M, tnew_M) ||
                   data_hz(rt_D, tuse_rt_D, wen_E, wa_E, tnew_E, wen_M, wa_M, tnew_M);
    md_stall_s   = md_use_D && (md_busy_r || md_start_E);
    if (reset) begin
      stall_s  = data_stall_s || md_stall_s;
      fwd_ae_s = fwd_e_sel(rs_E, wen_M, wa_M, tnew_M, wen_W, wa_W);
      fwd_be_s = fwd_e_sel(rt_E, wen_M, wa_M, tnew_M, wen_W, wa_W);
      fwd_ad_s = (rs_D != REG_ZERO) && wen_M && (wa_M == rs_D) && (tnew_M == 1'b0);
      fwd_bd_s = (rt_D != REG_ZERO) && wen_M && (wa_M == rt_D) && (tnew_M == 1'b0);
    end else begin
      stall_s  = 1'b0;
      fwd_ae_s = 2'b00;
      fwd_be_s = 2'b00;
      fwd_ad_s = 1'b0;
      fwd_bd_s = 1'b0;
    end
  end

  // MD latency counter next state; a start while busy is ignored.
  always_comb begin
    md_cnt_nxt_s = md_cnt_r;
    if (md_start_E && md_cnt_r == CNT_ZERO) begin
      if (md_div_E) begin
        md_cnt_nxt_s = DIV_LOAD;
      end else begin
        md_cnt_nxt_s = MUL_LOAD;
      end
    end else if (md_cnt_r != CNT_ZERO) begin
      md_cnt_nxt_s = md_cnt_r - CNT_ONE;
    end else begin
      md_cnt_nxt_s = CNT_ZERO;
    end
  end

  // MD counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_cnt_r  <= CNT_ZERO;
      md_busy_r <= 1'b0;
    end else begin
      md_cnt_r  <= md_cnt_nxt_s;
      md_busy_r <= (md_cnt_nxt_s != CNT_ZERO);
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] md_stall_cnt_r;

  // Saturating stall counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r    <= 32'd0;
      md_stall_cnt_r <= 32'd0;
    end else begin
      if (stall_s && stall_cnt_r != 32'hFFFF_FFFF) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (md_stall_s && md_stall_cnt_r != 32'hFFFF_FFFF) begin
        md_stall_cnt_r <= md_stall_cnt_r + 32'd1;
      end else begin
        md_stall_cnt_r <= md_stall_cnt_r;
      end
    end
  end

  assign stall_cnt    = stall_cnt_r;
  assign md_stall_cnt = md_stall_cnt_r;
`endif

  assign ForwardAD = fwd_ad_s;
  assign ForwardBD = fwd_bd_s;
  assign ForwardAE = fwd_ae_s;
  assign ForwardBE = fwd_be_s;
  assign stall     = stall_s;
  assign nop       = stall_s;
  assign md_busy   = md_busy_r;
  assign md_cnt    = md_cnt_r;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: table-driven combinational vectors plus MD counter / reset sequences.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_W;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E;
  logic       wen_E, wen_M, wen_W, tnew_M;
  logic       md_start_E, md_div_E, md_use_D;
  logic       ForwardAD, ForwardBD, stall, nop, md_busy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] md_cnt;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  hazard_unit_mc dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .rs_E(rs_E), .rt_E(rt_E), .wa_E(wa_E), .wa_M(wa_M), .wa_W(wa_W),
    .wen_E(wen_E), .wen_M(wen_M), .wen_W(wen_W), .tnew_E(tnew_E), .tnew_M(tnew_M),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall(stall), .nop(nop), .md_busy(md_busy),
`ifdef HAZ_PERF_EN
    .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
    .md_cnt(md_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic [1:0] tu_rs, tu_rt, tnew_e;
    logic       wen_e, wen_m, wen_w, tnew_m;
    logic [12:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] exp;
  } sb_t;

  sb_t   sb_q[$];
  vec_t  vecs[15];
  int    total  = 0;
  int    passed = 0;
  logic [12:0] act_s;

  assign act_s = {ForwardAD, ForwardBD, ForwardAE, ForwardBE, stall, nop, md_busy, md_cnt};

  function automatic logic [12:0] pk(input logic fad, input logic fbd, input logic [1:0] fae,
                                     input logic [1:0] fbe, input logic stl, input logic busy,
                                     input logic [3:0] cnt);
    return {fad, fbd, fae, fbe, stl, stl, busy, cnt};
  endfunction

  function automatic vec_t mk(input string n,
                              input logic [4:0] rsd, input logic [1:0] turs,
                              input logic [4:0] rtd, input logic [1:0] turt,
                              input logic [4:0] rse, input logic [4:0] rte,
                              input logic [4:0] wae, input logic wene, input logic [1:0] tne,
                              input logic [4:0] wam, input logic wenm, input logic tnm,
                              input logic [4:0] waw, input logic wenw, input logic [12:0] e);
    vec_t v;
    v.name = n; v.rs_d = rsd; v.tu_rs = turs; v.rt_d = rtd; v.tu_rt = turt;
    v.rs_e = rse; v.rt_e = rte; v.wa_e = wae; v.wen_e = wene; v.tnew_e = tne;
    v.wa_m = wam; v.wen_m = wenm; v.tnew_m = tnm; v.wa_w = waw; v.wen_w = wenw; v.exp = e;
    return v;
  endfunction

  task automatic clr();
    rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    rs_E = 5'd0; rt_E = 5'd0; wa_E = 5'd0; wa_M = 5'd0; wa_W = 5'd0;
    wen_E = 1'b0; wen_M = 1'b0; wen_W = 1'b0; tnew_E = 2'd0; tnew_M = 1'b0;
    md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0;
  endtask

  task automatic check_pop();
    sb_t e;
    total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got nothing required an entry");
    end else begin
      e = sb_q.pop_front();
      if (act_s === e.exp) passed++;
      else $display("FAIL %s: got %b required %b", e.name, act_s, e.exp);
    end
  endtask

  task automatic expect_now(input string n, input logic [12:0] e);
    sb_t s;
    s.name = n; s.exp = e;
    sb_q.push_back(s);
    #2;
    check_pop();
  endtask

  task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] e);
    total++;
    if (act === e) passed++;
    else $display("FAIL %s: got %0d required %0d", n, act, e);
  endtask

  initial begin
    //             name            rsD tu  rtD tu  rsE rtE waE wE tnE waM wM tM waW wW  expected
    vecs[0]  = mk("lw_E_stall",    8, 1,  0, 3,  0,  0,  8, 1, 2,  0, 0, 0,  0, 0, pk(0,0,2'b00,2'b00,1,0,0));
    vecs[1]  = mk("lw_M_tuse1",    8, 1,  0, 3,  0,  0,  0, 0, 0,  8, 1, 1,  0, 0, pk(0,0,2'b00,2'b00,0,0,0));
    vecs[2]  = mk("lw_M_tuse0",    8, 0,  0, 3,  0,  0,  0, 0, 0,  8, 1, 1,  0, 0, pk(0,0,2'b00,2'b00,1,0,0));
    vecs[3]  = mk("lw_W_fwd",      0, 3,  0, 3,  8,  0,  0, 0, 0,  0, 0, 0,  8, 1, pk(0,0,2'b01,2'b00,0,0,0));
    vecs[4]  = mk("fwd_M_pri",     0, 3,  0, 3,  9,  9,  0, 0, 0,  9, 1, 0,  9, 1, pk(0,0,2'b10,2'b10,0,0,0));
    vecs[5]  = mk("fwd_W_wam0",    0, 3,  0, 3,  9,  0,  0, 0, 0,  0, 1, 0,  9, 1, pk(0,0,2'b01,2'b00,0,0,0));
    vecs[6]  = mk("fwd_r0",        0, 0,  0, 0,  0,  0,  0, 1, 2,  0, 1, 0,  0, 1, pk(0,0,2'b00,2'b00,0,0,0));
    vecs[7]  = mk("beq_fwd_M",     4, 0,  0, 3,  0,  0,  0, 0, 0,  4, 1, 0,  0, 0, pk(1,0,2'b00,2'b00,0,0,0));
    vecs[8]  = mk("beq_stall_E",   4, 0,  0, 3,  0,  0,  4, 1, 1,  4, 1, 0,  0, 0, pk(1,0,2'b00,2'b00,1,0,0));
    vecs[9]  = mk("fwd_M_notrdy",  0, 3,  0, 3,  9,  0,  0, 0, 0,  9, 1, 1,  9, 1, pk(0,0,2'b01,2'b00,0,0,0));
    vecs[10] = mk("rt_stall",      0, 3,  5, 0,  0,  0,  5, 1, 1,  0, 0, 0,  0, 0, pk(0,0,2'b00,2'b00,1,0,0));
    vecs[11] = mk("tuse3_nostall", 8, 3,  0, 3,  0,  0,  8, 1, 2,  0, 0, 0,  0, 0, pk(0,0,2'b00,2'b00,0,0,0));
    vecs[12] = mk("rt_fwd_D",      0, 3,  7, 1,  0,  0,  0, 0, 0,  7, 1, 0,  0, 0, pk(0,1,2'b00,2'b00,0,0,0));
    vecs[13] = mk("wenE_off",      8, 0,  0, 3,  0,  0,  8, 0, 2,  0, 0, 0,  0, 0, pk(0,0,2'b00,2'b00,0,0,0));
    vecs[14] = mk("tnewE_eq_tuse", 8, 1,  0, 3,  0,  0,  8, 1, 1,  0, 0, 0,  0, 0, pk(0,0,2'b00,2'b00,0,0,0));

    reset = 1'b0;
    clr();
    @(negedge clk);
    @(negedge clk);
    rs_E = 5'd9; wa_M = 5'd9; wen_M = 1'b1; rs_D = 5'd8; tuse_rs_D = 2'd0;
    wa_E = 5'd8; wen_E = 1'b1; tnew_E = 2'd2; md_use_D = 1'b1; md_start_E = 1'b1;
    expect_now("reset_state", pk(0,0,2'b00,2'b00,0,0,4'd0));
    @(negedge clk);
    clr();
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      clr();
      rs_D = vecs[i].rs_d; tuse_rs_D = vecs[i].tu_rs; rt_D = vecs[i].rt_d; tuse_rt_D = vecs[i].tu_rt;
      rs_E = vecs[i].rs_e; rt_E = vecs[i].rt_e;
      wa_E = vecs[i].wa_e; wen_E = vecs[i].wen_e; tnew_E = vecs[i].tnew_e;
      wa_M = vecs[i].wa_m; wen_M = vecs[i].wen_m; tnew_M = vecs[i].tnew_m;
      wa_W = vecs[i].wa_w; wen_W = vecs[i].wen_w;
      expect_now(vecs[i].name, vecs[i].exp);
    end

    // div: 10 busy cycles, mflo in D stalled throughout; a forced start mid-run is ignored
    @(negedge clk);
    clr();
    md_start_E = 1'b1; md_div_E = 1'b1;
    expect_now("div_issue", pk(0,0,2'b00,2'b00,0,0,4'd0));
    @(negedge clk);
    clr();
    md_use_D = 1'b1;
    for (int k = 0; k < 10; k++) begin
      md_start_E = (k == 4);
      expect_now($sformatf("div_busy%0d", k), pk(0,0,2'b00,2'b00,1,1,4'(10 - k)));
      @(negedge clk);
    end
    md_start_E = 1'b0;
    expect_now("div_done", pk(0,0,2'b00,2'b00,0,0,4'd0));

    // mult interrupted by a one-edge reset at md_cnt = 3
    @(negedge clk);
    clr();
    md_start_E = 1'b1;
    expect_now("mul_issue", pk(0,0,2'b00,2'b00,0,0,4'd0));
    @(negedge clk);
    clr();
    md_use_D = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_now($sformatf("mul_busy%0d", k), pk(0,0,2'b00,2'b00,1,1,4'(5 - k)));
      if (k < 2) @(negedge clk);
    end
    reset = 1'b0;
    expect_now("rst_forces_zero", pk(0,0,2'b00,2'b00,0,1,4'd3));
    @(negedge clk);
    expect_now("rst_clears_cnt", pk(0,0,2'b00,2'b00,0,0,4'd0));
    reset = 1'b1;
    expect_now("rst_release", pk(0,0,2'b00,2'b00,0,0,4'd0));
    @(negedge clk);
    expect_now("rst_stays_idle", pk(0,0,2'b00,2'b00,0,0,4'd0));

`ifdef HAZ_PERF_EN
    @(negedge clk);
    clr();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk32("perf_reset_stall", stall_cnt, 32'd0);
    chk32("perf_reset_md", md_stall_cnt, 32'd0);
    rs_D = 5'd8; tuse_rs_D = 2'd0; wa_E = 5'd8; wen_E = 1'b1; tnew_E = 2'd1;
    repeat (3) @(negedge clk);
    clr();
    md_start_E = 1'b1;
    @(negedge clk);
    md_start_E = 1'b0;
    md_use_D = 1'b1;
    repeat (5) @(negedge clk);
    md_use_D = 1'b0;
    @(negedge clk);
    chk32("perf_stall_cnt", stall_cnt, 32'd8);
    chk32("perf_md_stall_cnt", md_stall_cnt, 32'd5);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
